// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample format, midscale code, PWM resolution
// and the volume scaler used when a sample is loaded into the PWM duty register.
package audio_pkg;

  localparam int unsigned AUD_SAMPLE_W = 8;
  localparam logic [7:0]  AUD_MIDSCALE = 8'h80;
  localparam int unsigned PWM_STEPS    = 256;

  typedef logic [AUD_SAMPLE_W-1:0] aud_sample_t;

  // Attenuate around midscale; an arithmetic shift of the signed offset keeps the result in 0..255.
  function automatic aud_sample_t scale_sample(input aud_sample_t sample, input logic [2:0] volume);
    logic signed [8:0] offset;
    logic signed [8:0] scaled;
    offset = $signed({1'b0, sample}) - 9'sd128;
    scaled = 9'sd128 + (offset >>> volume);
    return aud_sample_t'(scaled);
  endfunction

endpackage

// File: rtl/audio_pwm_dac_if.sv
// Valid/ready sample stream feeding the PWM DAC.
interface audio_pwm_dac_if;
  import audio_pkg::*;

  logic        valid;
  aud_sample_t data;
  logic        ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/audio_sample_fifo.sv
// Small synchronous sample FIFO with asynchronous clear and synchronous flush.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  aud_sample_t              wdata,
  output aud_sample_t              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  aud_sample_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/audio_pwm_dac.sv
// Audio output stage: buffers PCM samples, scales them by volume at each PWM
// period boundary and drives a 256-step PWM pin plus the amplifier enable.
module audio_pwm_dac
  import audio_pkg::*;
#(
  parameter int unsigned PRESCALE_MAX = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          HOLD_LAST    = 1'b1
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable_i,
  input  logic                          mute_i,
  input  logic [2:0]                    volume_i,
  audio_pwm_dac_if.slave                s,
  output logic                          aud_pwm,
  output logic                          aud_sd,
  output logic                          period_tick_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned CW = $clog2(PWM_STEPS);

  logic [5:0]    presc;
  logic [CW-1:0] cnt;
  aud_sample_t   duty;
  aud_sample_t   head;
  logic          full, empty;
  logic          tick, boundary, push, pop;

  assign tick     = enable_i && (presc == 6'(PRESCALE_MAX));
  assign boundary = tick && (cnt == CW'(PWM_STEPS - 1));

  // Reset gates ready so the stream never sees a handshake while state is held clear.
  assign s.ready       = enable_i && !full && !wb_rst_i;
  assign push          = s.valid && s.ready;
  assign pop           = boundary && !empty;
  assign period_tick_o = boundary;
  assign underrun_o    = boundary && empty;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (!enable_i),
    .push  (push),
    .pop   (pop),
    .wdata (s.data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level_o)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      presc   <= '0;
      cnt     <= '0;
      duty    <= AUD_MIDSCALE;
      aud_pwm <= 1'b0;
      aud_sd  <= 1'b0;
    end else if (!enable_i) begin
      presc   <= '0;
      cnt     <= '0;
      duty    <= AUD_MIDSCALE;
      aud_pwm <= 1'b0;
      aud_sd  <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      if (boundary) begin
        if (!empty)         duty <= scale_sample(head, volume_i);
        else if (!HOLD_LAST) duty <= AUD_MIDSCALE;
      end
      aud_pwm <= !mute_i && (cnt < duty);
      aud_sd  <= !mute_i;
    end
  end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac: two instances (hold-last and midscale-on-underrun)
// share clock and controls; duty is observed as aud_pwm high clocks per period.
module tb_audio_pwm_dac;
  import audio_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, mute;
  logic [2:0] volume;

  logic       pwm_h, sd_h, tick_h, under_h;
  logic       pwm_m, sd_m, tick_m, under_m;
  logic [2:0] level_h, level_m;

  audio_pwm_dac_if ifh ();
  audio_pwm_dac_if ifm ();

  audio_pwm_dac #(.PRESCALE_MAX(2), .FIFO_DEPTH(4), .HOLD_LAST(1'b1)) dut_h (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable), .mute_i(mute), .volume_i(volume),
    .s(ifh), .aud_pwm(pwm_h), .aud_sd(sd_h), .period_tick_o(tick_h),
    .underrun_o(under_h), .fifo_level_o(level_h)
  );

  audio_pwm_dac #(.PRESCALE_MAX(2), .FIFO_DEPTH(4), .HOLD_LAST(1'b0)) dut_m (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable), .mute_i(mute), .volume_i(volume),
    .s(ifm), .aud_pwm(pwm_m), .aud_sd(sd_m), .period_tick_o(tick_m),
    .underrun_o(under_m), .fifo_level_o(level_m)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // Results of the most recent period measurement.
  int         found, high_h, high_m, end_tick;
  logic       uh, um;
  logic [2:0] lvl_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Waits (bounded) for a period boundary, then counts high clocks over the following period.
  task automatic measure();
    int n = 0;
    high_h = 0;
    high_m = 0;
    while (tick_h !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    found  = (tick_h === 1'b1) ? 1 : 0;
    uh     = under_h;
    um     = under_m;
    lvl_at = level_h;
    for (int j = 1; j <= 768; j++) begin
      @(negedge clk);
      if (pwm_h === 1'b1) high_h++;
      if (pwm_m === 1'b1) high_m++;
    end
    end_tick = (tick_h === 1'b1) ? 1 : 0;
  endtask

  logic [7:0] samp [5];
  logic [2:0] vol_tab [5];
  int         duty_tab [5];
  logic       und_tab [5];
  int         c0, n;

  initial begin
    samp     = '{8'h40, 8'h00, 8'hFF, 8'h00, 8'h00};
    vol_tab  = '{3'd2, 3'd2, 3'd7, 3'd0, 3'd0};
    duty_tab = '{96, 159, 127, 0, 0};
    und_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; enable = 1'b0; mute = 1'b0; volume = 3'd0;
    ifh.valid = 1'b0; ifh.data = '0; ifm.valid = 1'b0; ifm.data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ifh.ready, 0);
    check("rst_pwm", pwm_h, 0);
    check("rst_sd", sd_h, 0);
    check("rst_tick", tick_h, 0);
    check("rst_underrun", under_h, 0);
    check("rst_level", level_h, 0);

    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    @(negedge clk);
    check("en_ready", ifh.ready, 1);

    // Fill the FIFO with valid held; the fifth sample waits for the first pop.
    for (int i = 0; i < 4; i++) begin
      ifh.data = samp[i]; ifh.valid = 1'b1;
      @(negedge clk);
    end
    ifh.data = samp[4];
    check("full_level", level_h, 4);
    check("full_ready", ifh.ready, 0);

    n = 0;
    while (tick_h !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("first_tick_found", tick_h, 1);
    check("first_tick_cycle", cyc - c0, 767);
    check("first_level_before_pop", level_h, 4);
    check("first_underrun_h", under_h, 0);
    check("first_underrun_m", under_m, 1);
    high_h = 0; high_m = 0;
    for (int j = 1; j <= 768; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("pop_level", level_h, 3);
        check("ready_after_pop", ifh.ready, 1);
      end
      if (j == 2) begin
        check("fifth_accepted", level_h, 4);
        ifh.valid = 1'b0;
      end
      if (pwm_h === 1'b1) high_h++;
      if (pwm_m === 1'b1) high_m++;
    end
    check("tick_interval", tick_h, 1);
    check("duty40_high", high_h, 192);
    check("mid_underrun_high", high_m, 384);

    // Scaling and hold-last over successive periods.
    for (int i = 0; i < 5; i++) begin
      volume = vol_tab[i];
      measure();
      check($sformatf("p%0d_tick", i + 2), found, 1);
      check($sformatf("p%0d_level", i + 2), lvl_at, 4 - i);
      check($sformatf("p%0d_underrun_h", i + 2), uh, und_tab[i]);
      check($sformatf("p%0d_underrun_m", i + 2), um, 1);
      check($sformatf("p%0d_high_h", i + 2), high_h, duty_tab[i] * 3);
      check($sformatf("p%0d_high_m", i + 2), high_m, 384);
    end

    // Mute: FIFO keeps draining, outputs silent, unmute resumes with the loaded duty.
    volume = 3'd0;
    @(negedge clk);
    ifh.data = 8'hFF; ifh.valid = 1'b1;
    repeat (2) @(negedge clk);
    ifh.valid = 1'b0;
    mute = 1'b1;
    @(negedge clk);
    check("mute_sd", sd_h, 0);
    check("mute_pwm", pwm_h, 0);
    check("mute_level", level_h, 2);
    measure();
    check("mute1_level", lvl_at, 2);
    check("mute1_high", high_h, 0);
    measure();
    check("mute2_level", lvl_at, 1);
    check("mute2_high", high_h, 0);
    check("mute2_drained", level_h, 0);
    mute = 1'b0;
    measure();
    check("unmute_underrun", uh, 1);
    check("unmute_high_hold", high_h, 765);
    check("unmute_sd", sd_h, 1);

    // A push landing on an empty-FIFO boundary is queued, not bypassed.
    ifh.data = 8'h20; ifh.valid = 1'b1;
    @(negedge clk);
    ifh.valid = 1'b0;
    check("boundary_push_level", level_h, 1);

    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_pwm", pwm_h, 0);
    check("midrst_sd", sd_h, 0);
    check("midrst_ready", ifh.ready, 0);
    check("midrst_tick", tick_h, 0);
    check("midrst_underrun", under_h, 0);
    check("midrst_level", level_h, 0);
    @(negedge clk);
    rst = 1'b0;
    measure();
    check("postrst_tick", found, 1);
    check("postrst_underrun", uh, 1);
    check("postrst_duty_mid", high_h, 384);

    // Disable flushes the FIFO and silences outputs on the next clock.
    @(negedge clk);
    ifh.data = 8'h10; ifh.valid = 1'b1;
    repeat (2) @(negedge clk);
    ifh.valid = 1'b0;
    check("pre_disable_level", level_h, 2);
    enable = 1'b0;
    @(negedge clk);
    check("dis_level", level_h, 0);
    check("dis_ready", ifh.ready, 0);
    check("dis_sd", sd_h, 0);
    check("dis_pwm", pwm_h, 0);
    check("dis_tick", tick_h, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
